fht_input_loader: RTL and testbench

- Streaming front end for fht_top. Accepts ADC samples one at a time over a valid/ready handshake.
- Writes each sample into the four radix-4 RAM banks through the iWE_0..3 / iADDR_WR / iDATA write port, using the bit-reversed bank order.
- After a full frame is written, pulses the FHT start input and holds off new samples until the transform reports ready. It then re-arms for the next frame.
- Generalises the fixed 1024-point load sequence to parametric frame size, data width and signedness. Adds overflow accounting and a clear command.

---
 rtl/fht_input_loader_if.sv | 31 +++
 rtl/fht_input_loader.sv | 169 ++++++++++++++++
 tb/tb_fht_input_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_input_loader_if.sv
// Sample-stream and RAM-write-port bundle between the ADC side, the loader
// and fht_top. The loader uses the slave view; whoever drives samples and
// watches the write port uses the master view.
interface fht_input_loader_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8,
  parameter int OVF_W = 16
) ();
  logic [D_BIT-2:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             iCLEAR;
  logic             iFHT_RDY;
  logic             oSTART;
  logic [D_BIT-1:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [3:0]       oWE;
  logic             oBUSY;
  logic             oDROP;
  logic [OVF_W-1:0] oOVF_CNT;

  modport slave (
    input  iDATA, iVALID, iCLEAR, iFHT_RDY,
    output oREADY, oSTART, oDATA, oADDR_WR, oWE, oBUSY, oDROP, oOVF_CNT
  );

  modport master (
    output iDATA, iVALID, iCLEAR, iFHT_RDY,
    input  oREADY, oSTART, oDATA, oADDR_WR, oWE, oBUSY, oDROP, oOVF_CNT
  );
endinterface

// File: rtl/fht_input_loader.sv
// Streaming front end for fht_top: accepts one ADC sample per handshake,
// scatters it into the four radix-4 banks in bit-reversed bank order, then
// starts the transform and holds off input until the transform is done.
module fht_input_loader #(
  parameter int N         = 1024,
  parameter int D_BIT     = 16,
  parameter int A_BIT     = 8,
  parameter int SIGNED_IN = 1,
  parameter int OVF_W     = 16
) (
  input logic                iCLK,
  input logic                iRESET,
  fht_input_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [A_BIT+1:0] K_LAST  = (A_BIT+2)'(N - 1);
  localparam logic [A_BIT+1:0] K_ONE   = (A_BIT+2)'(1);
  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};
  localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

  state_t           state_r, state_next;
  logic [A_BIT+1:0] k_r, k_next;
  logic             ready_r;
  logic             start_r;
  logic             busy_r;
  logic [D_BIT-1:0] data_r;
  logic [A_BIT-1:0] addr_r;
  logic [3:0]       we_r;
  logic             drop_r;
  logic [OVF_W-1:0] ovf_r;
  logic             accept_s;
  logic             drop_s;

  // Widen a D_BIT-1 sample to the RAM word, sign- or zero-extending.
  function automatic logic [D_BIT-1:0] extend(input logic [D_BIT-2:0] x);
    if (SIGNED_IN != 0) begin
      extend = {x[D_BIT-2], x};
    end else begin
      extend = {1'b0, x};
    end
  endfunction

  // One-hot bank enable for the bit-reversed 2-bit bank index.
  function automatic logic [3:0] bank_onehot(input logic [1:0] sel);
    case ({sel[0], sel[1]})
      2'd0:    bank_onehot = 4'b0001;
      2'd1:    bank_onehot = 4'b0010;
      2'd2:    bank_onehot = 4'b0100;
      2'd3:    bank_onehot = 4'b1000;
      default: bank_onehot = 4'b0000;
    endcase
  endfunction

  // A clear cancels a sample presented in the same cycle; a drop is any
  // sample offered while the loader is not ready.
  assign accept_s = bus.iVALID & ready_r & ~bus.iCLEAR;
  assign drop_s   = bus.iVALID & ~ready_r;

  // Next-state and sample-counter logic; clear overrides everything.
  always_comb begin
    state_next = state_r;
    k_next     = k_r;
    if (bus.iCLEAR) begin
      state_next = FILL;
      k_next     = '0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            k_next = k_r + K_ONE;
            if (k_r == K_LAST) begin
              state_next = START;
            end else begin
              state_next = FILL;
            end
          end else begin
            k_next = k_r;
          end
        end
        START: state_next = ACK;
        ACK: begin
          if (!bus.iFHT_RDY) begin
            state_next = RUN;
          end else begin
            state_next = ACK;
          end
        end
        RUN: begin
          if (bus.iFHT_RDY) begin
            state_next = FILL;
            k_next     = '0;
          end else begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = FILL;
          k_next     = '0;
        end
      endcase
    end
  end

  // State, counter and registered control outputs derived from next state.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_r <= FILL;
      k_r     <= '0;
      ready_r <= 1'b0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      k_r     <= k_next;
      ready_r <= (state_next == FILL);
      start_r <= (state_r == START) & ~bus.iCLEAR;
      busy_r  <= (state_next != FILL);
    end
  end

  // RAM write port: one-cycle enable per accepted sample, data/address hold.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      we_r   <= 4'b0000;
      data_r <= '0;
      addr_r <= '0;
    end else if (accept_s) begin
      we_r   <= bank_onehot(k_r[A_BIT+1:A_BIT]);
      data_r <= extend(bus.iDATA);
      addr_r <= k_r[A_BIT-1:0];
    end else begin
      we_r   <= 4'b0000;
    end
  end

  // Drop pulse and saturating dropped-sample counter.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      drop_r <= 1'b0;
      ovf_r  <= '0;
    end else begin
      drop_r <= drop_s;
      if (bus.iCLEAR) begin
        ovf_r <= '0;
      end else if (drop_s && (ovf_r != OVF_MAX)) begin
        ovf_r <= ovf_r + OVF_ONE;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign bus.oREADY   = ready_r;
  assign bus.oSTART   = start_r;
  assign bus.oBUSY    = busy_r;
  assign bus.oWE      = we_r;
  assign bus.oDATA    = data_r;
  assign bus.oADDR_WR = addr_r;
  assign bus.oDROP    = drop_r;
  assign bus.oOVF_CNT = ovf_r;

endmodule

// File: tb/tb_fht_input_loader.sv
// Self-checking bench for fht_input_loader: a 1024-point signed instance and
// a 16-point unsigned instance with a 3-bit drop counter.
module tb_fht_input_loader;

  localparam int N  = 1024;
  localparam int NB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_ovf  = 0;

  int       spot_k[5]    = '{0, 256, 300, 512, 1023};
  logic [3:0] spot_we[5] = '{4'b0001, 4'b0100, 4'b0100, 4'b0010, 4'b1000};
  int       spot_addr[5] = '{0, 0, 44, 0, 255};

  always #5 clk = ~clk;

  fht_input_loader_if #(.D_BIT(16), .A_BIT(8), .OVF_W(16)) bus ();
  fht_input_loader_if #(.D_BIT(16), .A_BIT(2), .OVF_W(3))  bus_b ();

  fht_input_loader #(.N(N), .D_BIT(16), .A_BIT(8), .SIGNED_IN(1), .OVF_W(16)) dut (
    .iCLK(clk), .iRESET(rst_n), .bus(bus)
  );

  fht_input_loader #(.N(NB), .D_BIT(16), .A_BIT(2), .SIGNED_IN(0), .OVF_W(3)) dut_b (
    .iCLK(clk), .iRESET(rst_n), .bus(bus_b)
  );

  // Reference: bank index is the quarter of the frame with its two bits swapped.
  function automatic int exp_we(int k, int n);
    int q, b;
    q = k / (n / 4);
    b = (q % 2) * 2 + (q / 2);
    return 1 << b;
  endfunction

  function automatic int exp_addr(int k, int n);
    return k % (n / 4);
  endfunction

  // Reference: 15-bit sample as a 16-bit word, two's complement when signed.
  function automatic int exp_ext(int x, bit sgn);
    if (sgn && x >= 16384) return x - 32768 + 65536;
    return x;
  endfunction

  task automatic test_reset();
    bus.iVALID = 1'b1; bus.iDATA = 15'h1234; bus.iCLEAR = 1'b0; bus.iFHT_RDY = 1'b1;
    bus_b.iVALID = 1'b1; bus_b.iDATA = 15'h0042; bus_b.iCLEAR = 1'b0; bus_b.iFHT_RDY = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.oREADY, bus.oSTART, bus.oWE, bus.oBUSY, bus.oDROP} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b start=%b we=%b busy=%b drop=%b, want all 0",
               bus.oREADY, bus.oSTART, bus.oWE, bus.oBUSY, bus.oDROP);
    end
    checks++;
    if ({bus.oDATA, bus.oADDR_WR, bus.oOVF_CNT} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got data=%h addr=%h ovf=%h, want 0", bus.oDATA, bus.oADDR_WR, bus.oOVF_CNT);
    end
    bus.iVALID = 1'b0; bus_b.iVALID = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oREADY !== 1'b1 || bus_b.oREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", bus.oREADY, bus_b.oREADY);
    end
  endtask

  task automatic test_unsigned_ovf();
    int x;
    int exp_cnt;
    for (int k = 0; k < NB; k++) begin
      x = (k == 0) ? 16384 : (k == 1) ? 16383 : int'($urandom_range(0, 32767));
      bus_b.iVALID = 1'b1; bus_b.iDATA = 15'(x);
      @(negedge clk);
      checks++;
      if ({bus_b.oWE, bus_b.oADDR_WR, bus_b.oDATA} !==
          {4'(exp_we(k, NB)), 2'(exp_addr(k, NB)), 16'(exp_ext(x, 1'b0))}) begin
        errors++;
        $display("FAIL unsigned_write k=%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                 k, bus_b.oWE, bus_b.oADDR_WR, bus_b.oDATA, 4'(exp_we(k, NB)), exp_addr(k, NB), 16'(exp_ext(x, 1'b0)));
      end
      if (k < 2) begin
        checks++;
        if (bus_b.oDATA !== ((k == 0) ? 16'h4000 : 16'h3FFF)) begin
          errors++;
          $display("FAIL zero_extend k=%0d: got %h", k, bus_b.oDATA);
        end
      end
    end
    bus_b.iVALID = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_b.oSTART !== 1'b1) begin
      errors++; $display("FAIL b_start: got %b, want 1", bus_b.oSTART);
    end
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      bus_b.iVALID = 1'b1; bus_b.iDATA = 15'($urandom);
      @(negedge clk);
      if (exp_cnt < 7) exp_cnt++;
      checks++;
      if (bus_b.oDROP !== 1'b1 || bus_b.oREADY !== 1'b0) begin
        errors++; $display("FAIL b_drop %0d: got drop=%b rdy=%b, want 1/0", i, bus_b.oDROP, bus_b.oREADY);
      end
    end
    bus_b.iVALID = 1'b0;
    checks++;
    if (bus_b.oOVF_CNT !== 3'(exp_cnt)) begin
      errors++; $display("FAIL ovf_saturate: got %0d, want %0d", bus_b.oOVF_CNT, exp_cnt);
    end
    bus_b.iCLEAR = 1'b1;
    @(negedge clk);
    bus_b.iCLEAR = 1'b0;
    checks++;
    if ({bus_b.oOVF_CNT, bus_b.oBUSY, bus_b.oREADY, bus_b.oSTART} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clear_busy: got ovf=%0d busy=%b rdy=%b start=%b, want 0/0/1/0",
               bus_b.oOVF_CNT, bus_b.oBUSY, bus_b.oREADY, bus_b.oSTART);
    end
  endtask

  task automatic test_frame(input bit use_gaps);
    int k, x, guard;
    bit v;
    k = 0; guard = 0;
    while (k < N && guard < 8 * N) begin
      v = use_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      x = use_gaps ? int'($urandom_range(0, 32767)) : k;
      bus.iVALID = v; bus.iDATA = 15'(x);
      if (use_gaps) bus.iFHT_RDY = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      checks++;
      if (v) begin
        if ({bus.oWE, bus.oADDR_WR, bus.oDATA} !==
            {4'(exp_we(k, N)), 8'(exp_addr(k, N)), 16'(exp_ext(x, 1'b1))}) begin
          errors++;
          $display("FAIL write k=%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                   k, bus.oWE, bus.oADDR_WR, bus.oDATA, 4'(exp_we(k, N)), exp_addr(k, N), 16'(exp_ext(x, 1'b1)));
        end
        for (int s = 0; s < 5; s++) begin
          if (!use_gaps && spot_k[s] == k) begin
            checks++;
            if (bus.oWE !== spot_we[s] || int'(bus.oADDR_WR) != spot_addr[s]) begin
              errors++;
              $display("FAIL bank_map k=%0d: got we=%b addr=%0d, want we=%b addr=%0d",
                       k, bus.oWE, bus.oADDR_WR, spot_we[s], spot_addr[s]);
            end
          end
        end
        k++;
      end else if (bus.oWE !== 4'b0000) begin
        errors++; $display("FAIL idle_we: got %b, want 0000", bus.oWE);
      end
      checks++;
      if (bus.oREADY !== (k < N) || bus.oSTART !== 1'b0) begin
        errors++;
        $display("FAIL fill_ready k=%0d: got rdy=%b start=%b, want rdy=%b start=0", k, bus.oREADY, bus.oSTART, (k < N));
      end
    end
    checks++;
    if (k != N) begin
      errors++; $display("FAIL frame_timeout: got %0d samples, want %0d", k, N);
    end
    bus.iVALID = 1'b0; bus.iFHT_RDY = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oSTART !== 1'b1 || bus.oWE !== 4'b0000) begin
      errors++; $display("FAIL start_pulse: got start=%b we=%b, want 1/0000", bus.oSTART, bus.oWE);
    end
    @(negedge clk);
    checks++;
    if (bus.oSTART !== 1'b0) begin
      errors++; $display("FAIL start_single: got %b, want 0", bus.oSTART);
    end
  endtask

  task automatic test_handshake(input int n_drop);
    int sent;
    bit v;
    sent = 0;
    for (int c = 0; c < 105; c++) begin
      bus.iFHT_RDY = (c < 5);
      v = (sent < n_drop);
      if (v) sent++;
      bus.iVALID = v; bus.iDATA = 15'($urandom);
      @(negedge clk);
      if (v && m_ovf < 65535) m_ovf++;
      checks++;
      if ({bus.oBUSY, bus.oREADY, bus.oDROP, bus.oWE, bus.oSTART} !== {1'b1, 1'b0, v, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL busy_hold c=%0d: got busy=%b rdy=%b drop=%b we=%b start=%b, want 1/0/%b/0000/0",
                 c, bus.oBUSY, bus.oREADY, bus.oDROP, bus.oWE, bus.oSTART, v);
      end
    end
    checks++;
    if (int'(bus.oOVF_CNT) != m_ovf) begin
      errors++; $display("FAIL ovf_count: got %0d, want %0d", bus.oOVF_CNT, m_ovf);
    end
    bus.iVALID = 1'b0; bus.iFHT_RDY = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oREADY !== 1'b1 || bus.oBUSY !== 1'b0) begin
      errors++; $display("FAIL rearm: got rdy=%b busy=%b, want 1/0", bus.oREADY, bus.oBUSY);
    end
  endtask

  task automatic test_signed_extension();
    bus.iVALID = 1'b1; bus.iDATA = 15'h4000;
    @(negedge clk);
    checks++;
    if ({bus.oWE, bus.oADDR_WR, bus.oDATA} !== {4'b0001, 8'd0, 16'hC000}) begin
      errors++; $display("FAIL sign_extend_neg: got we=%b addr=%0d data=%h, want 0001/0/C000", bus.oWE, bus.oADDR_WR, bus.oDATA);
    end
    bus.iDATA = 15'h3FFF;
    @(negedge clk);
    checks++;
    if ({bus.oWE, bus.oADDR_WR, bus.oDATA} !== {4'b0001, 8'd1, 16'h3FFF}) begin
      errors++; $display("FAIL sign_extend_pos: got we=%b addr=%0d data=%h, want 0001/1/3FFF", bus.oWE, bus.oADDR_WR, bus.oDATA);
    end
    bus.iVALID = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 98; i++) begin
      bus.iVALID = 1'b1; bus.iDATA = 15'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oREADY, bus.oWE, bus.oDATA, bus.oADDR_WR, bus.oBUSY, bus.oDROP, bus.oOVF_CNT} !== 47'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%b we=%b data=%h addr=%h ovf=%h, want 0",
               bus.oREADY, bus.oWE, bus.oDATA, bus.oADDR_WR, bus.oOVF_CNT);
    end
    bus.iVALID = 1'b0;
    m_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.iVALID = 1'b1; bus.iDATA = 15'h0101;
    @(negedge clk);
    bus.iVALID = 1'b0;
    checks++;
    if (bus.oWE !== 4'b0001 || bus.oADDR_WR !== 8'd0) begin
      errors++; $display("FAIL mid_reset_restart: got we=%b addr=%0d, want 0001/0", bus.oWE, bus.oADDR_WR);
    end
  endtask

  task automatic test_clear();
    bus.iCLEAR = 1'b1;
    @(negedge clk);
    bus.iCLEAR = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      bus.iVALID = 1'b1; bus.iDATA = 15'($urandom);
      @(negedge clk);
    end
    bus.iVALID = 1'b1; bus.iCLEAR = 1'b1;
    @(negedge clk);
    bus.iVALID = 1'b0; bus.iCLEAR = 1'b0;
    checks++;
    if (bus.oWE !== 4'b0000 || bus.oREADY !== 1'b1) begin
      errors++; $display("FAIL clear_last: got we=%b rdy=%b, want 0000/1", bus.oWE, bus.oREADY);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.oSTART !== 1'b0 || bus.oREADY !== 1'b1 || bus.oBUSY !== 1'b0) begin
        errors++;
        $display("FAIL clear_no_start c=%0d: got start=%b rdy=%b busy=%b, want 0/1/0", c, bus.oSTART, bus.oREADY, bus.oBUSY);
      end
    end
    bus.iVALID = 1'b1; bus.iDATA = 15'h0777;
    @(negedge clk);
    bus.iVALID = 1'b0;
    checks++;
    if (bus.oWE !== 4'b0001 || bus.oADDR_WR !== 8'd0) begin
      errors++; $display("FAIL clear_restart: got we=%b addr=%0d, want 0001/0", bus.oWE, bus.oADDR_WR);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_ovf();
    test_frame(1'b0);
    test_handshake(10);
    test_frame(1'b1);
    test_handshake(int'($urandom_range(1, 20)));
    test_signed_extension();
    test_mid_reset();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
